rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Two-requester arbiter for the single-port 1024×32 instruction ROM (`addr`/`dout`, combinational read). It shares the ROM between the core's instruction-fetch port (IF) and a data-read port (DR) used for constant loads from program memory. It grants at most one port per cycle and registers the ROM word into that port's read-data register. Each port sees a fixed one-cycle read latency with a req/gnt/valid handshake. It sits between the fetch stage and load unit on one side and the ROM on the other.

## Interface
- ADDR_W, 10, ROM word-address width (1024 positions)
- DATA_W, 32, ROM word width
- MAX_WAIT, 4, consecutive denied DR-request cycles after which DR is forced ahead of IF (1..15)

- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_valid  out  1  if_rdata valid (registered)
- if_rdata  out  DATA_W  fetched instruction
- dr_req  in  1  data-read request
- dr_addr  in  ADDR_W  data-read word address
- dr_gnt  out  1  data request accepted this cycle (combinational)
- dr_valid  out  1  dr_rdata valid (registered)
- dr_rdata  out  DATA_W  read data
- rom_addr  out  ADDR_W  to ROM `addr`
- rom_dout  in  DATA_W  from ROM `dout`

## Operation
- Each cycle, at most one of if_gnt/dr_gnt is high. A grant occurs only for an asserted req.
- Requester holds req and addr stable until it sees gnt high at a rising edge. It may drop req only after the grant.
- rom_addr = granted port's addr. With no grant, rom_addr = 0.
- On the edge where x_gnt=1: x_rdata <= rom_dout, and x_valid <= 1 for exactly the next cycle.
- x_rdata holds its value until the next grant to the same port.
- Default policy, fixed priority: IF wins over DR.
- Starvation guard: wait_cnt (4 bits) increments each cycle dr_req=1 and dr_gnt=0. It clears on dr_gnt or when dr_req=0.
- When wait_cnt == MAX_WAIT, DR wins over IF in that cycle.
- last_gnt flag (0=IF, 1=DR) updates on every grant and holds otherwise.
- Back-to-back grants to one port are allowed every cycle, giving full throughput.
- Reset mid-operation: all registers clear immediately. Any outstanding valid is lost and the requester must re-request.

## Timing
- Reset values: if_valid=0, dr_valid=0, if_rdata=0, dr_rdata=0, wait_cnt=0, last_gnt=1. gnt and rom_addr follow the combinational rules.
- Request at cycle N with no contention: gnt in cycle N, valid and data in cycle N+1.
- Both requesting under default policy: IF is granted each cycle. DR is granted at the latest in cycle N+MAX_WAIT.
- gnt is combinational from req and state only. No combinational path from rom_dout to any output.

## Configuration
- ROM_RR_EN defined: round-robin replaces fixed priority.
  - On contention, the port opposite to last_gnt wins.
  - After reset (last_gnt=1), IF wins the first contention.
  - wait_cnt and MAX_WAIT logic are removed, since round-robin already bounds waiting to 1 cycle.
- ROM_RR_EN undefined: fixed priority with starvation guard as described above.

## Test plan
- Reset then single IF read: ROM preloaded with 32'h10000197 at 0 and 32'h0001a383 at 1. if_req=1, if_addr=0 -> if_gnt same cycle. Next cycle if_valid=1, if_rdata=32'h10000197.
- Streaming: if_addr 0,1,2,3 on consecutive cycles -> if_valid high 4 consecutive cycles with 32'h10000197, 32'h0001a383, 32'h00818413, 32'h00418493.
- Contention, default, MAX_WAIT=4: if_req and dr_req (addr 3) held high.
  - IF is granted for cycles 0..3, DR is granted in cycle 4.
  - Next cycle dr_rdata=32'h00418493.
  - IF resumes in cycle 5.
- Contention with ROM_RR_EN: both held high -> grants alternate IF, DR, IF, DR, starting with IF after reset.
- Async reset asserted the cycle after a DR grant -> dr_valid=0 immediately, dr_rdata=0, and no valid pulse after release.
- Idle: no req -> no gnt, rom_addr=0, both valids stay 0 and rdata registers are unchanged.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Purpose : shares the single-port instruction ROM between fetch (IF) and data-read (DR) ports.
// Latency : grant is combinational in the request cycle; read data and valid appear one cycle later.
// Backpr. : a requester that is not granted holds req/addr. Fixed IF priority with a DR starvation guard.
//           Building with ROM_RR_EN defined replaces this with round-robin on contention.
//
// Ports:
//   i_clk, i_rst              clock (rising edge), asynchronous active-high reset
//   i_if_req, i_if_addr       fetch request and word address
//   o_if_gnt                  fetch accepted this cycle (combinational)
//   o_if_valid, o_if_rdata    registered fetch data, valid for one cycle
//   i_dr_req, i_dr_addr       data-read request and word address
//   o_dr_gnt                  data read accepted this cycle (combinational)
//   o_dr_valid, o_dr_rdata    registered read data, valid for one cycle
//   o_rom_addr, i_rom_dout    ROM address out, combinational ROM word in
//
// Configuration macro: ROM_RR_EN (round-robin arbitration when defined).
module rom_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dr_req,
  input  logic [ADDR_W-1:0] i_dr_addr,
  output logic              o_dr_gnt,
  output logic              o_dr_valid,
  output logic [DATA_W-1:0] o_dr_rdata,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_dout
);

  logic w_if_gnt;
  logic w_dr_gnt;

`ifdef ROM_RR_EN
  // 0 = IF was granted last, 1 = DR was granted last. Reset to DR so that IF
  // wins the first contention.
  logic r_last_gnt;

  assign w_if_gnt = i_if_req && (!i_dr_req || r_last_gnt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_gnt <= 1'b1;
    end else if (w_if_gnt) begin
      r_last_gnt <= 1'b0;
    end else if (w_dr_gnt) begin
      r_last_gnt <= 1'b1;
    end
  end
`else
  // Counts consecutive cycles in which DR was requesting but lost to IF.
  logic [3:0] r_wait_cnt;
  logic       w_dr_force;

  assign w_dr_force = i_dr_req && (r_wait_cnt == 4'(MAX_WAIT));
  assign w_if_gnt   = i_if_req && !w_dr_force;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt <= 4'd0;
    end else if (w_dr_gnt || !i_dr_req) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != 4'hF) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end
`endif

  // DR only takes the ROM when IF does not, so grants are mutually exclusive.
  assign w_dr_gnt = i_dr_req && !w_if_gnt;

  assign o_if_gnt   = w_if_gnt;
  assign o_dr_gnt   = w_dr_gnt;
  assign o_rom_addr = w_if_gnt ? i_if_addr :
                      w_dr_gnt ? i_dr_addr : '0;

  // Read-data registers load only on their own grant and otherwise hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_if_valid <= 1'b0;
      o_dr_valid <= 1'b0;
      o_if_rdata <= '0;
      o_dr_rdata <= '0;
    end else begin
      o_if_valid <= w_if_gnt;
      o_dr_valid <= w_dr_gnt;
      if (w_if_gnt) begin
        o_if_rdata <= i_rom_dout;
      end
      if (w_dr_gnt) begin
        o_dr_rdata <= i_rom_dout;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [9:0]  if_addr = '0;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dr_req = 1'b0;
  logic [9:0]  dr_addr = '0;
  logic        dr_gnt;
  logic        dr_valid;
  logic [31:0] dr_rdata;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;

  logic [31:0] rom_img [1024];

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } exp_t;

  exp_t q_if[$];
  exp_t q_dr[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [31:0] last_if_dat = '0;
  logic [31:0] last_dr_dat = '0;

  rom_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_valid(if_valid), .o_if_rdata(if_rdata),
    .i_dr_req(dr_req), .i_dr_addr(dr_addr), .o_dr_gnt(dr_gnt),
    .o_dr_valid(dr_valid), .o_dr_rdata(dr_rdata),
    .o_rom_addr(rom_addr), .i_rom_dout(rom_dout)
  );

  assign rom_dout = rom_img[rom_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus with the hand-derived grant outcome for that cycle.
  task automatic step(input logic ireq, input logic [9:0] ia, input logic dreq,
                      input logic [9:0] da, input logic e_ig, input logic e_dg,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if_req = ireq; if_addr = ia; dr_req = dreq; dr_addr = da;
    #1;
    chk({nm, "_if_gnt"}, {31'd0, if_gnt}, {31'd0, e_ig});
    chk({nm, "_dr_gnt"}, {31'd0, dr_gnt}, {31'd0, e_dg});
    chk({nm, "_rom_addr"}, {22'd0, rom_addr}, e_ig ? {22'd0, ia} : e_dg ? {22'd0, da} : 32'd0);
    if (e_ig) begin
      e.cyc = cyc + 1; e.dat = rom_img[ia];
      q_if.push_back(e); last_if_dat = e.dat;
    end
    if (e_dg) begin
      e.cyc = cyc + 1; e.dat = rom_img[da];
      q_dr.push_back(e); last_dr_dat = e.dat;
    end
  endtask

  // Monitor: every valid must match the oldest expectation, in the expected cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_valid) begin
        if (q_if.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
        else begin
          e = q_if.pop_front();
          chk("if_rdata", if_rdata, e.dat);
          chk("if_valid_cycle", cyc, e.cyc);
        end
      end
      if (dr_valid) begin
        if (q_dr.size() == 0) chk("dr_valid_unexpected", 32'd1, 32'd0);
        else begin
          e = q_dr.pop_front();
          chk("dr_rdata", dr_rdata, e.dat);
          chk("dr_valid_cycle", cyc, e.cyc);
        end
      end
      if (q_if.size() > 0 && q_if[0].cyc < cyc) begin
        chk("if_valid_missing", 32'd0, 32'd1);
        void'(q_if.pop_front());
      end
      if (q_dr.size() > 0 && q_dr[0].cyc < cyc) begin
        chk("dr_valid_missing", 32'd0, 32'd1);
        void'(q_dr.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom_img[i] = 32'hA5000000 ^ i;
    rom_img[0] = 32'h10000197;
    rom_img[1] = 32'h0001a383;
    rom_img[2] = 32'h00818413;
    rom_img[3] = 32'h00418493;

    // Reset values
    #1;
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_dr_valid", {31'd0, dr_valid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dr_rdata", dr_rdata, 32'd0);
    chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single IF read of address 0
    step(1, 10'd0, 0, 10'd0, 1, 0, "single");
    step(0, 10'd0, 0, 10'd0, 0, 0, "single_idle");
    chk("single_if_rdata_const", if_rdata, 32'h10000197);

    // Streaming fetch, addresses 0..3 back to back
    for (int k = 0; k < 4; k++) step(1, 10'(k), 0, 10'd0, 1, 0, "stream");
    step(0, 10'd0, 0, 10'd0, 0, 0, "stream_end");
    chk("stream_last_const", if_rdata, 32'h00418493);

    // Idle: no grants, rom_addr 0, rdata registers hold
    for (int k = 0; k < 3; k++) begin
      step(0, 10'd0, 0, 10'd0, 0, 0, "idle");
      chk("idle_if_hold", if_rdata, last_if_dat);
      chk("idle_dr_hold", dr_rdata, last_dr_dat);
    end

    // DR grant, then asynchronous reset during its valid cycle
    step(0, 10'd0, 1, 10'd2, 0, 1, "drrst");
    @(posedge clk);
    #1;
    dr_req = 1'b0;
    chk("drrst_valid_before", {31'd0, dr_valid}, 32'd1);
    chk("drrst_rdata_before", dr_rdata, 32'h00818413);
    rst = 1'b1;
    q_if.delete(); q_dr.delete();
    last_if_dat = '0; last_dr_dat = '0;
    #1;
    chk("drrst_valid_after", {31'd0, dr_valid}, 32'd0);
    chk("drrst_rdata_after", dr_rdata, 32'd0);
    chk("drrst_if_rdata_after", if_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) step(0, 10'd0, 0, 10'd0, 0, 0, "post_rst");
    chk("post_rst_dr_rdata", dr_rdata, 32'd0);

`ifdef ROM_RR_EN
    // Round-robin: contention alternates IF, DR, IF, DR starting with IF
    for (int k = 0; k < 4; k++)
      step(1, 10'(k), 1, 10'd3, (k % 2) == 0, (k % 2) == 1, "rr");
    step(0, 10'd0, 0, 10'd0, 0, 0, "rr_end");
    chk("rr_dr_rdata_const", dr_rdata, 32'h00418493);
`else
    // Fixed priority with starvation guard, MAX_WAIT=4: IF in 0..3, DR in 4
    for (int k = 0; k < 5; k++)
      step(1, 10'(k % 4), 1, 10'd3, k != 4, k == 4, "cont");
    // DR drops req after its grant; IF resumes
    step(1, 10'd1, 0, 10'd3, 1, 0, "cont_resume");
    chk("cont_dr_rdata_const", dr_rdata, 32'h00418493);
    step(0, 10'd0, 0, 10'd0, 0, 0, "cont_end");
    // Guard re-arms: DR again waits exactly MAX_WAIT cycles
    for (int k = 0; k < 6; k++)
      step(1, 10'd2, k < 5, 10'd5, k != 4, k == 4, "cont2");
    step(0, 10'd0, 0, 10'd0, 0, 0, "cont2_end");
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("q_if_drained", q_if.size(), 32'd0);
    chk("q_dr_drained", q_dr.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
